// File: rtl/pixel_frame_buffer.sv
// Dual-port pixel frame buffer with a hardware fill engine.
// Port A: CPU read/write; port B: read-only VGA fetch; fill floods the frame one pixel per cycle.
module pixel_frame_buffer #(
  parameter int unsigned X_BITS = 8,
  parameter int unsigned Y_BITS = 7,
  parameter int unsigned PIX_W  = 1,
  localparam int unsigned ADDR_W = X_BITS + Y_BITS
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [PIX_W-1:0]  i_a_data_in,
  input  logic              i_a_we,
  output logic [PIX_W-1:0]  o_a_data_out,
  output logic              o_a_busy,
  input  logic              i_clr_start,
  input  logic [PIX_W-1:0]  i_clr_colour,
  output logic              o_clr_done,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [PIX_W-1:0]  o_b_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_count, w_count_next;
  logic [PIX_W-1:0]    r_colour, w_colour_next;
  logic [PIX_W-1:0]    r_a_data, r_b_data;
  logic [PIX_W-1:0]    r_mem [DEPTH];

  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [PIX_W-1:0]    w_mem_wdata;
  logic                w_a_rd_en;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_colour <= '0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_colour <= w_colour_next;
    end
  end

  // Port 1 write mux: CPU owns it except while the fill engine is running.
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_colour_next = r_colour;
    w_mem_we      = 1'b0;
    w_mem_addr    = i_a_addr;
    w_mem_wdata   = i_a_data_in;
    w_a_rd_en     = 1'b0;
    case (r_state)
      StIdle: begin
        w_a_rd_en = 1'b1;
        w_mem_we  = i_a_we;
        if (i_clr_start) begin
          w_state_next  = StFill;
          w_count_next  = '0;
          w_colour_next = i_clr_colour;
        end
      end
      StFill: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_count;
        w_mem_wdata = r_colour;
        if (r_count == {ADDR_W{1'b1}}) begin
          w_state_next = StDone;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      StDone: begin
        w_a_rd_en    = 1'b1;
        w_mem_we     = i_a_we;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Both read ports are read-first: a same-edge write is not visible until the next read.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_a_data <= '0;
      r_b_data <= '0;
    end else begin
      r_b_data <= r_mem[i_b_addr];
      if (w_a_rd_en) begin
        r_a_data <= r_mem[i_a_addr];
      end
    end
  end

  assign o_a_data_out = r_a_data;
  assign o_b_data     = r_b_data;
  assign o_a_busy     = (r_state == StFill);
  assign o_clr_done   = (r_state == StDone);

endmodule
